mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the RV32IC 5-stage pipeline.
- Consumes the MEM_STATE pipeline register and produces the WBACK_STATE register for write-back.
- Drives a single-port data-memory req/ack handshake, with byte-lane steering for stores and sign/zero extension for loads.
- Stalls upstream stages while a data access is outstanding.

Parameters:
- DMEM_TIMEOUT, 0, cycles to wait for dmem_ack before flagging bus_err; 0 = wait forever.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_in  in  $bits(MEM_STATE)  stage input register contents.
- mem_valid  in  1  mem_in carries a live instruction.
- stall_out  out  1  hold IF/ID/EX and MEM_STATE register.
- wb_out  out  $bits(WBACK_STATE)  registered write-back state.
- wb_valid  out  1  wb_out is live this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned address ({ALUOutput[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
- dmem_rdata  in  32  load word.
- bus_err  out  1  one-cycle pulse on DMEM_TIMEOUT expiry.
- misalign_trap  out  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (async):
  - state=IDLE.
  - wb_out all zero; wb_valid, dmem_req, bus_err, misalign_trap = 0.
  - Timeout counter = 0.
- mem_type encoding (package constants):
  - [1:0] size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
  - [2]: 1 = unsigned load.
  - [3]: reserved, ignored.
- Access = mem_valid & (MemRead | MemWrite). MemRead & MemWrite both set: treated as store.
- Non-access, mem_valid=1:
  - Next edge: wb_out = {pc, RegWrite, rd, write_reg}, wb_valid=1.
  - Latency 1, no stall.
- mem_valid=0: next edge wb_valid=0 and wb_out.RegWrite=0. Other wb_out fields hold.
- FSM IDLE:
  - On access, dmem_req=1 combinationally, together with addr/be/wdata/we.
  - stall_out = access & ~dmem_ack.
  - Ack in same cycle: complete at next edge and stay IDLE.
  - Otherwise go to WAIT.
- FSM WAIT:
  - dmem_req held high; addr/be/wdata/we are stable (MEM_STATE is frozen by stall).
  - stall_out=1 until the dmem_ack cycle, in which stall_out=0.
  - On ack: complete at next edge and return to IDLE.
- Completion:
  - wb_valid=1, with pc, rd and RegWrite from mem_in.
  - final_out = MemToReg ? load_ext : write_reg.
  - A store completes with RegWrite forced 0.
- Byte enables (a = ALUOutput[1:0]):
  - Byte: 1<<a.
  - Half: a[1] ? 1100 : 0011.
  - Word: 1111.
- Store data: byte replicated x4, half replicated x2, word as-is (from rd2).
- Load extract:
  - Byte: dmem_rdata[8a+7:8a].
  - Half: a[1] selects upper or lower 16 bits.
  - Extend with zeros if mem_type[2], otherwise sign-extend.
- Timeout (DMEM_TIMEOUT>0):
  - Counter increments each WAIT cycle without ack.
  - At count==DMEM_TIMEOUT: bus_err pulse; drop req; complete with RegWrite=0; return to IDLE.
- Reset asserted mid-WAIT: request is abandoned immediately (dmem_req=0). The access is not retried.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Half with a[0]=1, or word with a!=0, issues no dmem_req and does not stall.
  - Next edge: misalign_trap=1 for one cycle, wb_valid=1, RegWrite=0.
- Undefined:
  - Misalignment is ignored; low address bits are dropped as per the be/extract rules (half uses a[1]; word uses lane 0).
  - misalign_trap is tied 0.

Decomposition:
- Package PipelineReg gains:
  - MEM_SZ_B/H/W localparams.
  - MEM_UNSIGNED_BIT.
  - typedef enum logic {MS_IDLE, MS_WAIT} mem_fsm_t.
- Sub-module mem_lane_align (combinational): size/offset/unsigned -> be, wdata, load_ext.

Test Plan:
- ALU op, write_reg=0x1234, rd=5, RegWrite=1, no mem -> next cycle wb_valid=1, final_out=0x1234, stall_out never asserted.
- Store byte, ALUOutput=0x103, rd2=0xAB -> dmem_be=1000, dmem_wdata=0xABABABAB, addr=0x100, ack after 3 cycles -> stall_out high 3 cycles, wb RegWrite=0.
- Load byte signed at a=2, rdata=0x00800000, ack same cycle -> final_out=0xFFFFFF80, no stall. Same with mem_type[2]=1 -> 0x00000080.
- Load half at a=2, rdata=0x8001_0000, unsigned -> final_out=0x00008001.
- DMEM_TIMEOUT=4, no ack -> stall 4 cycles, bus_err pulse, RegWrite=0, FSM back to IDLE.
- With macro, word load at 0x102 -> no dmem_req, misalign_trap pulse, RegWrite=0. Without macro -> req to 0x100, be=1111.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Pipeline register layouts and memory-access encodings shared by the MEM stage.
package PipelineReg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;
    localparam int         MEM_UNSIGNED_BIT = 2;

    typedef enum logic {MS_IDLE, MS_WAIT} mem_fsm_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ALUOutput;
        logic [31:0] rd2;
        logic [31:0] write_reg;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
        logic [3:0]  mem_type;
    } MEM_STATE;

    typedef struct packed {
        logic [31:0] pc;
        logic        RegWrite;
        logic [4:0]  rd;
        logic [31:0] final_out;
    } WBACK_STATE;

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for stores and sign/zero extension for loads.
module mem_lane_align
    import PipelineReg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        misaligned
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    assign b_sel = rdata[8*off +: 8];
    assign h_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata      = st_data;
        load_ext   = rdata;
        misaligned = 1'b0;
        case (size)
            MEM_SZ_B: begin
                be       = 4'b0001 << off;
                wdata    = {4{st_data[7:0]}};
                load_ext = uns ? {24'h0, b_sel} : {{24{b_sel[7]}}, b_sel};
            end
            MEM_SZ_H: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{st_data[15:0]}};
                load_ext   = uns ? {16'h0, h_sel} : {{16{h_sel[15]}}, h_sel};
                misaligned = off[0];
            end
            // word and the reserved size both use the full lane-0 word
            default: misaligned = (off != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32IC memory-access stage: data-memory handshake, stall generation, WBACK register.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage
    import PipelineReg::*;
#(
    parameter int DMEM_TIMEOUT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$bits(MEM_STATE)-1:0]   mem_in,
    input  logic                          mem_valid,
    output logic                          stall_out,
    output logic [$bits(WBACK_STATE)-1:0] wb_out,
    output logic                          wb_valid,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [31:0]                   dmem_addr,
    output logic [3:0]                    dmem_be,
    output logic [31:0]                   dmem_wdata,
    input  logic                          dmem_ack,
    input  logic [31:0]                   dmem_rdata,
    output logic                          bus_err,
    output logic                          misalign_trap
);

    localparam bit          TMO_EN   = (DMEM_TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(DMEM_TIMEOUT - 1) : 32'h0;

    MEM_STATE   m;
    WBACK_STATE wb_r;
    mem_fsm_t   state;
    logic [31:0] tmo_cnt;
    logic [31:0] load_ext;
    logic        misaligned;
    logic        access, go, trap_evt, req_c, tmo_fire, done;
    logic        unused_bits;

    assign m = MEM_STATE'(mem_in);

    mem_lane_align u_align (
        .size       (m.mem_type[1:0]),
        .off        (m.ALUOutput[1:0]),
        .uns        (m.mem_type[MEM_UNSIGNED_BIT]),
        .st_data    (m.rd2),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_ext   (load_ext),
        .misaligned (misaligned)
    );

    assign access = mem_valid & (m.MemRead | m.MemWrite);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign go          = access & ~misaligned;
    assign trap_evt    = access & misaligned;
    assign unused_bits = m.mem_type[3];
`else
    assign go          = access;
    assign trap_evt    = 1'b0;
    assign unused_bits = ^{m.mem_type[3], misaligned};
`endif

    // Reset drops the request at once; an abandoned access is never replayed.
    assign req_c    = ~rst & ((state == MS_IDLE && go) || state == MS_WAIT);
    assign tmo_fire = TMO_EN && state == MS_WAIT && !dmem_ack && tmo_cnt == TMO_LAST;
    assign done     = req_c & (dmem_ack | tmo_fire);

    assign dmem_req  = req_c;
    assign dmem_we   = m.MemWrite;
    assign dmem_addr = {m.ALUOutput[31:2], 2'b00};
    assign stall_out = req_c & ~dmem_ack & ~tmo_fire;
    assign wb_out    = wb_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MS_IDLE;
            tmo_cnt       <= '0;
            wb_r          <= '0;
            wb_valid      <= 1'b0;
            bus_err       <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            bus_err       <= tmo_fire;
            misalign_trap <= trap_evt;

            case (state)
                MS_IDLE: begin
                    tmo_cnt <= '0;
                    if (go && !dmem_ack) state <= MS_WAIT;
                end
                MS_WAIT: begin
                    if (dmem_ack || tmo_fire) state <= MS_IDLE;
                    else                      tmo_cnt <= tmo_cnt + 32'd1;
                end
                default: state <= MS_IDLE;
            endcase

            if (done) begin
                wb_valid       <= 1'b1;
                wb_r.pc        <= m.pc;
                wb_r.rd        <= m.rd;
                wb_r.RegWrite  <= m.RegWrite & ~m.MemWrite & ~tmo_fire;
                wb_r.final_out <= m.MemToReg ? load_ext : m.write_reg;
            end else if (trap_evt) begin
                wb_valid       <= 1'b1;
                wb_r.pc        <= m.pc;
                wb_r.rd        <= m.rd;
                wb_r.RegWrite  <= 1'b0;
                wb_r.final_out <= m.write_reg;
            end else if (mem_valid && !access) begin
                wb_valid       <= 1'b1;
                wb_r.pc        <= m.pc;
                wb_r.rd        <= m.rd;
                wb_r.RegWrite  <= m.RegWrite;
                wb_r.final_out <= m.write_reg;
            end else begin
                // bubble or still waiting on memory: nothing retires this cycle
                wb_valid      <= 1'b0;
                wb_r.RegWrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage, built with a 4-cycle data-memory timeout.
module tb_mem_stage;
    import PipelineReg::*;

    localparam int TMO = 4;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [$bits(MEM_STATE)-1:0]   mem_in = '0;
    logic                          mem_valid = 1'b0;
    logic                          stall_out;
    logic [$bits(WBACK_STATE)-1:0] wb_out;
    logic                          wb_valid;
    logic                          dmem_req, dmem_we;
    logic [31:0]                   dmem_addr, dmem_wdata;
    logic [3:0]                    dmem_be;
    logic                          dmem_ack = 1'b0;
    logic [31:0]                   dmem_rdata = '0;
    logic                          bus_err, misalign_trap;

    WBACK_STATE wbs;
    assign wbs = WBACK_STATE'(wb_out);

    always #5 clk = ~clk;

    mem_stage #(.DMEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mem_in(mem_in), .mem_valid(mem_valid),
        .stall_out(stall_out), .wb_out(wb_out), .wb_valid(wb_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .bus_err(bus_err), .misalign_trap(misalign_trap)
    );

    int tests = 0;
    int fails = 0;
    WBACK_STATE exp_q[$];
    WBACK_STATE e;
    int stalls, reqs;
    logic [31:0] o_addr, o_wd;
    logic [3:0]  o_be;
    logic        o_we;

    function automatic MEM_STATE mk(input logic [31:0] pc, alu, rd2, wr, input logic [4:0] rd,
                                    input logic regw, mr, mw, m2r, input logic [3:0] mt);
        MEM_STATE s;
        s.pc = pc; s.ALUOutput = alu; s.rd2 = rd2; s.write_reg = wr; s.rd = rd;
        s.RegWrite = regw; s.MemRead = mr; s.MemWrite = mw; s.MemToReg = m2r; s.mem_type = mt;
        return s;
    endfunction

    function automatic WBACK_STATE wb(input logic [31:0] pc, input logic regw,
                                      input logic [4:0] rd, input logic [31:0] fo);
        WBACK_STATE w;
        w.pc = pc; w.RegWrite = regw; w.rd = rd; w.final_out = fo;
        return w;
    endfunction

    // Presents one instruction, answers the request after ack_lat cycles (-1 = never),
    // and returns at the negedge after the retiring edge.
    task automatic drive(input MEM_STATE s, input int ack_lat, input logic [31:0] rdata);
        int  k;
        bit  fin;
        @(negedge clk);
        mem_in = s; mem_valid = 1'b1;
        stalls = 0; reqs = 0; fin = 0; k = 0;
        o_addr = '0; o_be = '0; o_wd = '0; o_we = 1'b0;
        while (!fin && k < 50) begin
            dmem_ack = (k == ack_lat); dmem_rdata = rdata;
            #1;
            if (dmem_req) begin
                reqs++; o_addr = dmem_addr; o_be = dmem_be; o_wd = dmem_wdata; o_we = dmem_we;
            end
            if (stall_out) stalls++; else fin = 1;
            @(negedge clk);
            k++;
        end
        mem_valid = 1'b0; dmem_ack = 1'b0;
        if (!fin) begin
            tests++; fails++;
            $display("FAIL drive_bound stall never released after %0d cycles", k);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (wb_out !== '0 || wb_valid !== 1'b0 || dmem_req !== 1'b0 || bus_err !== 1'b0 ||
            misalign_trap !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got wb=%h v=%b req=%b berr=%b trap=%b exp all 0",
                     wb_out, wb_valid, dmem_req, bus_err, misalign_trap);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_alu();
        exp_q.push_back(wb(32'h40, 1'b1, 5'd5, 32'h1234));
        drive(mk(32'h40, 32'h9999, 32'h0, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2), 0, '0);
        tests++;
        if (stalls !== 0 || reqs !== 0) begin
            fails++; $display("FAIL alu_nostall got stalls=%0d reqs=%0d exp 0/0", stalls, reqs);
        end
        e = exp_q.pop_front(); tests++;
        if (wb_valid !== 1'b1 || wbs !== e) begin
            fails++; $display("FAIL alu_wb got v=%b %h exp v=1 %h", wb_valid, wbs, e);
        end
        // bubble: valid and RegWrite drop, remaining fields hold
        @(negedge clk); tests++;
        if (wb_valid !== 1'b0 || wbs.RegWrite !== 1'b0 || wbs.pc !== 32'h40 ||
            wbs.final_out !== 32'h1234) begin
            fails++; $display("FAIL bubble_hold got v=%b %h exp v=0 pc=40 fo=1234 rw=0", wb_valid, wbs);
        end
    endtask

    task automatic test_store_byte();
        exp_q.push_back(wb(32'h44, 1'b0, 5'd7, 32'h55));
        drive(mk(32'h44, 32'h103, 32'hAB, 32'h55, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0), 3, '0);
        tests++;
        if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_wd !== 32'hABABABAB || o_we !== 1'b1) begin
            fails++; $display("FAIL sb_bus got a=%h be=%b wd=%h we=%b exp 100/1000/abababab/1",
                              o_addr, o_be, o_wd, o_we);
        end
        tests++;
        if (stalls !== 3) begin
            fails++; $display("FAIL sb_stall got %0d exp 3", stalls);
        end
        e = exp_q.pop_front(); tests++;
        if (wb_valid !== 1'b1 || wbs !== e) begin
            fails++; $display("FAIL sb_wb got v=%b %h exp v=1 %h", wb_valid, wbs, e);
        end
        // half store at a=2: upper lanes, halfword replicated
        drive(mk(32'h48, 32'h202, 32'h1234BEEF, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1), 0, '0);
        tests++;
        if (o_addr !== 32'h200 || o_be !== 4'b1100 || o_wd !== 32'hBEEFBEEF) begin
            fails++; $display("FAIL sh_bus got a=%h be=%b wd=%h exp 200/1100/beefbeef", o_addr, o_be, o_wd);
        end
    endtask

    task automatic test_loads();
        logic [3:0] mt [3]  = '{4'h0, 4'h4, 4'h5};
        logic [31:0] ad [3] = '{32'h302, 32'h302, 32'h302};
        logic [31:0] rd [3] = '{32'h00800000, 32'h00800000, 32'h80010000};
        logic [31:0] ex [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001};
        logic [3:0]  bx [3] = '{4'b0100, 4'b0100, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wb(32'h80 + 32'(i), 1'b1, 5'd9, ex[i]));
            drive(mk(32'h80 + 32'(i), ad[i], 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, mt[i]), 0, rd[i]);
            tests++;
            if (stalls !== 0 || reqs !== 1 || o_be !== bx[i] || o_we !== 1'b0 || o_addr !== 32'h300) begin
                fails++; $display("FAIL load%0d_bus got st=%0d rq=%0d be=%b we=%b a=%h exp 0/1/%b/0/300",
                                  i, stalls, reqs, o_be, o_we, o_addr, bx[i]);
            end
            e = exp_q.pop_front(); tests++;
            if (wb_valid !== 1'b1 || wbs !== e) begin
                fails++; $display("FAIL load%0d_wb got v=%b %h exp v=1 %h", i, wb_valid, wbs, e);
            end
        end
    endtask

    task automatic test_timeout();
        drive(mk(32'hC0, 32'h400, 32'h0, 32'h77, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2), -1, '0);
        tests++;
        if (stalls !== TMO) begin
            fails++; $display("FAIL tmo_stall got %0d exp %0d", stalls, TMO);
        end
        tests++;
        if (bus_err !== 1'b1 || wb_valid !== 1'b1 || wbs.RegWrite !== 1'b0 || wbs.pc !== 32'hC0) begin
            fails++; $display("FAIL tmo_wb got berr=%b v=%b rw=%b pc=%h exp 1/1/0/c0",
                              bus_err, wb_valid, wbs.RegWrite, wbs.pc);
        end
        @(negedge clk); tests++;
        if (bus_err !== 1'b0 || dmem_req !== 1'b0) begin
            fails++; $display("FAIL tmo_pulse got berr=%b req=%b exp 0/0", bus_err, dmem_req);
        end
        // back in IDLE: a same-cycle ack retires without stalling
        drive(mk(32'hC4, 32'h400, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2), 0, 32'h600D);
        tests++;
        if (stalls !== 0 || wbs.final_out !== 32'h600D || wbs.RegWrite !== 1'b1) begin
            fails++; $display("FAIL tmo_idle got st=%0d fo=%h rw=%b exp 0/600d/1", stalls, wbs.final_out, wbs.RegWrite);
        end
    endtask

    task automatic test_misalign();
        drive(mk(32'hD0, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2), 0, 32'hDEADBEEF);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        tests++;
        if (reqs !== 0 || stalls !== 0 || misalign_trap !== 1'b1 || wb_valid !== 1'b1 ||
            wbs.RegWrite !== 1'b0) begin
            fails++; $display("FAIL misalign_trap got rq=%0d st=%0d trap=%b v=%b rw=%b exp 0/0/1/1/0",
                              reqs, stalls, misalign_trap, wb_valid, wbs.RegWrite);
        end
        @(negedge clk); tests++;
        if (misalign_trap !== 1'b0) begin
            fails++; $display("FAIL misalign_pulse got %b exp 0", misalign_trap);
        end
`else
        tests++;
        if (reqs !== 1 || o_addr !== 32'h100 || o_be !== 4'b1111 || misalign_trap !== 1'b0 ||
            wbs.final_out !== 32'hDEADBEEF) begin
            fails++; $display("FAIL misalign_ign got rq=%0d a=%h be=%b trap=%b fo=%h exp 1/100/1111/0/deadbeef",
                              reqs, o_addr, o_be, misalign_trap, wbs.final_out);
        end
`endif
    endtask

    task automatic test_back_to_back();
        MEM_STATE s [3];
        s[0] = mk(32'hE0, 32'h0, 32'h0, 32'hA1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        s[1] = mk(32'hE4, 32'h501, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
        s[2] = mk(32'hE8, 32'h500, 32'h5A, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        exp_q.push_back(wb(32'hE0, 1'b1, 5'd10, 32'hA1));
        exp_q.push_back(wb(32'hE4, 1'b1, 5'd11, 32'h00000012));
        exp_q.push_back(wb(32'hE8, 1'b0, 5'd12, 32'h0));
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front(); tests++;
                if (wb_valid !== 1'b1 || wbs !== e) begin
                    fails++; $display("FAIL b2b%0d_wb got v=%b %h exp v=1 %h", i - 1, wb_valid, wbs, e);
                end
            end
            if (i < 3) begin
                mem_in = s[i]; mem_valid = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h00001200;
                #1; tests++;
                if (stall_out !== 1'b0) begin
                    fails++; $display("FAIL b2b%0d_stall got %b exp 0", i, stall_out);
                end
            end else begin
                mem_valid = 1'b0; dmem_ack = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        mem_in = mk(32'hF0, 32'h700, 32'h0, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2);
        mem_valid = 1'b1; dmem_ack = 1'b0;
        @(negedge clk); #1; tests++;
        if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
            fails++; $display("FAIL wait_req got req=%b stall=%b exp 1/1", dmem_req, stall_out);
        end
        rst = 1'b1; #1; tests++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
            fails++; $display("FAIL rst_abandon got req=%b v=%b exp 0/0", dmem_req, wb_valid);
        end
        mem_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); tests++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
            fails++; $display("FAIL rst_noretry got req=%b v=%b exp 0/0", dmem_req, wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_byte();
        test_loads();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
